// File: rtl/lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store controller that sits directly in front of the core's
// byte-addressed data memory. It takes one request at a time from the
// execute stage and drives the memory's 1-cycle-latency read port and its
// size-coded write port. Load data is sign- or zero-extended. The result, or
// a fault, goes to writeback over a valid/ready response channel.
//
// Optional feature (compile-time macro):
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword and word
//                          accesses fault at accept and never touch memory.
//                          When undefined, the memory handles any alignment.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_store             1 = store, 0 = load
//   req_funct3            RV32I size/sign code (B, H, W, BU, HU)
//   req_addr              byte address, passed through unchanged
//   req_wdata             right-aligned store data
//   req_rd                destination register tag
//   resp_valid/resp_ready response handshake to writeback
//   resp_we               load result must be written back
//   resp_rd               echoed register tag
//   resp_data             extended load data (0 for stores and faults)
//   resp_fault            illegal or misaligned access
//   mem_rd_addr           memory read address
//   mem_rd_data           memory read data, one cycle after mem_rd_addr
//   mem_wr                write size: 0 none, 1 byte, 2 half, 3 word
//   mem_wr_addr           memory write address
//   mem_wr_data           right-aligned memory write data
// ----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [1:0]        mem_wr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       respData_q, respData_d;
    logic              respWe_q, respWe_d;
    logic              respFault_q, respFault_d;

    logic              misaligned;
    logic              reqIllegal;
    logic [31:0]       loadExt;
    logic [1:0]        wrSize;

    // Misalignment only matters when the trap is built in. Halfword codes
    // (H, HU) share funct3[1:0] = 01 and the word code is 10.
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Codes 011, 110 and 111 are never legal. The unsigned codes (funct3[2])
    // make no sense for stores.
    assign reqIllegal = (req_funct3 == 3'b011) ||
                        (req_funct3[2:1] == 2'b11) ||
                        (req_store && req_funct3[2]) ||
                        misaligned;

    // Extend the right-aligned read data according to the registered code.
    always_comb begin
        loadExt = mem_rd_data;
        case (funct3_q)
            3'b000:  loadExt = {{24{mem_rd_data[7]}}, mem_rd_data[7:0]};
            3'b001:  loadExt = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
            3'b100:  loadExt = {24'd0, mem_rd_data[7:0]};
            3'b101:  loadExt = {16'd0, mem_rd_data[15:0]};
            default: loadExt = mem_rd_data;
        endcase
    end

    // Store size encoding for the memory write port. Only B, H and W stores
    // reach ACCESS, so the other codes never drive a write.
    always_comb begin
        wrSize = 2'd0;
        case (funct3_q[1:0])
            2'b00:   wrSize = 2'd1;
            2'b01:   wrSize = 2'd2;
            2'b10:   wrSize = 2'd3;
            default: wrSize = 2'd0;
        endcase
    end

    // Next-state and datapath updates. Response fields are settled before
    // entering RESP and are not touched there, so they stay stable under
    // back-pressure.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        respData_d  = respData_q;
        respWe_d    = respWe_q;
        respFault_d = respFault_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d    = req_store;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rd_d       = req_rd;
                    respData_d = 32'd0;
                    if (reqIllegal) begin
                        respFault_d = 1'b1;
                        respWe_d    = 1'b0;
                        state_d     = RESP;
                    end else begin
                        respFault_d = 1'b0;
                        respWe_d    = ~req_store;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = store_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                respData_d = loadExt;
                state_d    = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset returns to IDLE, which drops any
    // in-flight request and removes the write strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            respData_q  <= 32'd0;
            respWe_q    <= 1'b0;
            respFault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            respData_q  <= respData_d;
            respWe_q    <= respWe_d;
            respFault_q <= respFault_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_we     = respWe_q;
    assign resp_rd     = rd_q;
    assign resp_data   = respData_q;
    assign resp_fault  = respFault_q;

    assign mem_rd_addr = addr_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = wdata_q;
    assign mem_wr      = ((state_q == ACCESS) && store_q) ? wrSize : 2'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Self-checking bench for lsu_mem_ctrl. A byte-array memory with a registered
// read port stands in for the data memory. A separate byte-array reference
// model predicts every response, the latency, and the write strobe. The
// sequence is the directed scenarios followed by randomized requests.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [1:0]  mem_wr;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    int checksTotal;
    int checksPassed;
    int wrCycles;
    logic [1:0] lastWr;

    logic [7:0] dutMem [256];
    logic [7:0] refMem [256];

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_we     (resp_we),
        .resp_rd     (resp_rd),
        .resp_data   (resp_data),
        .resp_fault  (resp_fault),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr      (mem_wr),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory stand-in: the low 8 address bits index the array, the
    // write is sized, and the read is registered.
    always @(posedge clk) begin
        if (mem_wr != 2'd0) begin
            dutMem[mem_wr_addr[7:0]] <= mem_wr_data[7:0];
            if (mem_wr >= 2'd2)
                dutMem[8'(mem_wr_addr[7:0] + 8'd1)] <= mem_wr_data[15:8];
            if (mem_wr == 2'd3) begin
                dutMem[8'(mem_wr_addr[7:0] + 8'd2)] <= mem_wr_data[23:16];
                dutMem[8'(mem_wr_addr[7:0] + 8'd3)] <= mem_wr_data[31:24];
            end
        end
        mem_rd_data <= {dutMem[8'(mem_rd_addr[7:0] + 8'd3)],
                        dutMem[8'(mem_rd_addr[7:0] + 8'd2)],
                        dutMem[8'(mem_rd_addr[7:0] + 8'd1)],
                        dutMem[mem_rd_addr[7:0]]};
    end

    // Count the cycles in which the write strobe is active.
    always @(negedge clk) begin
        if (mem_wr != 2'd0) begin
            wrCycles <= wrCycles + 1;
            lastWr   <= mem_wr;
        end
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference model: decides legality and predicts load data from the
    // byte array, using language-level signed casts.
    function automatic bit refIllegal(input bit isStore, input logic [2:0] f3,
                                      input logic [31:0] addr);
        int nBytes;
        bit bad;
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (isStore && f3 >= 3'd4);
        nBytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        if (TRAP_EN && !bad && (addr % nBytes) != 0) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] w;
        int v;
        w = 32'd0;
        for (int i = 0; i < 4; i++) w = w | (32'(refMem[(addr + i) % 256]) << (8 * i));
        case (f3)
            3'd0:    v = int'(byte'(w[7:0]));
            3'd1:    v = int'(shortint'(w[15:0]));
            3'd4:    v = int'(w % 256);
            3'd5:    v = int'(w % 65536);
            default: v = int'(w);
        endcase
        return 32'(v);
    endfunction

    // Issue one request, wait for its response, and apply back-pressure for
    // holdCycles cycles. Then check the response, latency and write strobe,
    // and retire the request into the reference memory.
    task automatic applyStimulus(input bit isStore, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input int holdCycles);
        bit bad;
        int expLat;
        int lat;
        int wrStart;
        logic [31:0] expData;
        logic [31:0] snapData;
        logic [4:0]  snapRd;
        logic        snapWe;
        logic        snapFault;
        int nBytes;

        bad     = refIllegal(isStore, f3, addr);
        expLat  = bad ? 1 : (isStore ? 2 : 3);
        expData = (bad || isStore) ? 32'd0 : refLoad(f3, addr);

        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        wrStart    = wrCycles;
        req_valid  = 1'b1;
        req_store  = isStore;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        if (!resp_valid) begin
            checkOutput("resp_timeout", 32'(lat), 32'(expLat));
            return;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));

        snapData  = resp_data;
        snapRd    = resp_rd;
        snapWe    = resp_we;
        snapFault = resp_fault;
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold_ready", 32'(req_ready), 32'd0);
            checkOutput("hold_data", resp_data, snapData);
            checkOutput("hold_rd", 32'(resp_rd), 32'(snapRd));
            checkOutput("hold_flags", {30'd0, resp_we, resp_fault}, {30'd0, snapWe, snapFault});
        end

        checkOutput("resp_data", resp_data, expData);
        checkOutput("resp_we", 32'(resp_we), 32'(!bad && !isStore));
        checkOutput("resp_fault", 32'(resp_fault), 32'(bad));
        checkOutput("resp_rd", 32'(resp_rd), 32'(rd));
        nBytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        checkOutput("wr_cycles", 32'(wrCycles - wrStart), 32'((!bad && isStore) ? 1 : 0));
        if (!bad && isStore)
            checkOutput("wr_size", 32'(lastWr), 32'(nBytes == 4 ? 3 : nBytes));

        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput("resp_drop", 32'(resp_valid), 32'd0);

        if (!bad && isStore) begin
            for (int i = 0; i < nBytes; i++) refMem[(addr + i) % 256] = wdata[8*i +: 8];
        end
    endtask

    // Assert reset while a store sits in ACCESS. The write strobe must vanish
    // at once and every response output must return to its reset value.
    task automatic resetDuringStore(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = 5'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("rst_pre_wr", 32'(mem_wr), 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wr", 32'(mem_wr), 32'd0);
        checkOutput("rst_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_flags", {30'd0, resp_we, resp_fault}, 32'd0);
        checkOutput("rst_data", resp_data, 32'd0);
        checkOutput("rst_rd", 32'(resp_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        wrCycles     = 0;
        lastWr       = 2'd0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_funct3   = 3'd0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_rd       = 5'd0;
        resp_ready   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            refMem[i] = 8'($urandom);
            dutMem[i] = refMem[i];
        end

        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_wr", 32'(mem_wr), 32'd0);
        checkOutput("reset_resp", {resp_data[31:7], resp_rd, resp_we, resp_fault}, 32'd0);
        rst_n = 1'b1;

        // Directed scenarios
        applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd1, 0);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 5'd2, 0);
        checkOutput("lw_literal", refLoad(3'd2, 32'h10), 32'hDEADBEEF);
        applyStimulus(1'b0, 3'd0, 32'h13, 32'h0, 5'd3, 0);
        applyStimulus(1'b0, 3'd4, 32'h13, 32'h0, 5'd4, 0);
        applyStimulus(1'b0, 3'd1, 32'h12, 32'h0, 5'd5, 1);
        applyStimulus(1'b0, 3'd5, 32'h10, 32'h0, 5'd6, 0);
        applyStimulus(1'b1, 3'd0, 32'h11, 32'h55, 5'd7, 0);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 5'd8, 0);
        checkOutput("sb_merge", refLoad(3'd2, 32'h10), 32'hDEAD55EF);
        applyStimulus(1'b0, 3'd3, 32'h20, 32'h0, 5'd10, 0);
        applyStimulus(1'b1, 3'd4, 32'h20, 32'h12345678, 5'd11, 0);
        applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, 5'd12, 0);
        applyStimulus(1'b0, 3'd2, 32'h11, 32'h0, 5'd13, 0);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 5'd14, 5);

        resetDuringStore(32'h40, 32'hCAFEF00D);
        applyStimulus(1'b0, 3'd2, 32'h40, 32'h0, 5'd15, 0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            applyStimulus(1'($urandom), 3'($urandom_range(0, 7)),
                          {24'($urandom), 8'($urandom)}, $urandom,
                          5'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
